qam_tx_sequencer: RTL and testbench

Transmit sequencer for the QAM modulator chain. Accepts a serial bit stream over a valid/ready handshake, packs bit pairs into 2-bit sign symbols for the mixer, and drives the carrier LUT phase address and sample enable. Symbol changes are aligned to carrier-period boundaries. It replaces the free-running enable counter and serial-to-parallel stage with one controlled scheduler that supports start, stop and underrun.

---
 rtl/qam_tx_sequencer_if.sv | 42 ++++
 rtl/qam_tx_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_qam_tx_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/qam_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// qam_tx_sequencer_if
// Bundles the signals of the QAM transmit sequencer other than clk and rst.
// The control pulses and the serial bit stream flow from master to slave. The
// LUT address, the sample strobe, the symbol and the status flow back.
//   start, stop        : control pulses (master -> slave)
//   bit_in, bit_valid  : serial data with valid (master -> slave)
//   bit_ready          : sequencer accepts a bit this cycle (slave -> master)
//   phase_addr         : carrier LUT address, ADDR_W bits
//   en_sample          : one-cycle LUT read strobe
//   symbol_out         : [1] sine sign, [0] cosine sign
//   symbol_strobe      : pulses for one cycle when symbol_out loads
//   tx_active          : mixer unmute
//   underrun           : sticky starvation flag
// -----------------------------------------------------------------------------
interface qam_tx_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              stop;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [ADDR_W-1:0] phase_addr;
  logic              en_sample;
  logic [1:0]        symbol_out;
  logic              symbol_strobe;
  logic              tx_active;
  logic              underrun;

  modport master (
    output start, stop, bit_in, bit_valid,
    input  bit_ready, phase_addr, en_sample, symbol_out, symbol_strobe,
           tx_active, underrun
  );

  modport slave (
    input  start, stop, bit_in, bit_valid,
    output bit_ready, phase_addr, en_sample, symbol_out, symbol_strobe,
           tx_active, underrun
  );
endinterface

// File: rtl/qam_tx_sequencer.sv
// -----------------------------------------------------------------------------
// qam_tx_sequencer
// Transmit scheduler for the QAM modulator chain. It packs serial bits in pairs
// into 2-bit sign symbols. It steps the carrier LUT phase address on a
// prescaled sample tick. A new symbol loads only at the last sample of the last
// carrier period, so symbol changes land on carrier-period boundaries.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : qam_tx_sequencer_if.slave (control, bit stream, LUT/mixer outputs)
//
// Parameters:
//   LUT_DEPTH          : samples per carrier period (power of two, >= 4)
//   PERIODS_PER_SYMBOL : carrier periods per symbol (>= 1)
//   PRESCALE           : sample tick every PRESCALE+1 clocks
//
// Optional feature macro: QAM_SEQ_PREAMBLE_EN
//   When this macro is defined, start sends the fixed preamble 11,00,11,00
//   before any data. Bits may prefill the buffer while the preamble plays.
// -----------------------------------------------------------------------------
module qam_tx_sequencer #(
  parameter int LUT_DEPTH          = 64,
  parameter int PERIODS_PER_SYMBOL = 4,
  parameter int PRESCALE           = 0
) (
  input  logic              clk,
  input  logic              rst,
  qam_tx_sequencer_if.slave bus
);

  localparam int AW = $clog2(LUT_DEPTH);
  localparam int PW = (PERIODS_PER_SYMBOL > 1) ? $clog2(PERIODS_PER_SYMBOL) : 1;
  localparam int SW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  localparam logic [AW-1:0] PHASE_LAST  = AW'(LUT_DEPTH - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIODS_PER_SYMBOL - 1);
  localparam logic [SW-1:0] PRE_LAST    = SW'(PRESCALE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN
`ifdef QAM_SEQ_PREAMBLE_EN
    , S_PREAMBLE
`endif
  } state_e;

  state_e        state_q;
  logic [1:0]    buf_q, buf_d;      // next-symbol buffer, first bit in [1]
  logic [1:0]    count_q, count_d;  // bits held in buf_q, 0..2
  logic [SW-1:0] presc_q;
  logic [AW-1:0] phase_q;
  logic [PW-1:0] period_q;
  logic [1:0]    symbol_q;
  logic          strobe_q;
  logic          tx_active_q;
  logic          underrun_q;
  logic          stop_req_q;
`ifdef QAM_SEQ_PREAMBLE_EN
  logic [1:0]    pre_idx_q;         // preamble symbol currently on air
`endif

  logic running, tick, boundary, bit_ready, accept, stop_pend;

`ifdef QAM_SEQ_PREAMBLE_EN
  assign running = (state_q == S_RUN) || (state_q == S_PREAMBLE);
`else
  assign running = (state_q == S_RUN);
`endif

  assign tick      = running && (presc_q == PRE_LAST);
  assign boundary  = tick && (phase_q == PHASE_LAST) && (period_q == PERIOD_LAST);
  assign bit_ready = (state_q != S_IDLE) && (count_q != 2'd2);
  assign accept    = bus.bit_valid && bit_ready;
  assign stop_pend = stop_req_q || bus.stop;

  // Buffer contents after this edge's transfer, so FILL can launch the symbol
  // on the same edge that the second bit arrives.
  always_comb begin
    // NOTE: defaulting every output first keeps this block free of latches.
    buf_d   = buf_q;
    count_d = count_q;
    if (accept) begin
      if (count_q == 2'd0) buf_d[1] = bus.bit_in;
      else                 buf_d[0] = bus.bit_in;
      count_d = count_q + 2'd1;
    end
  end

  // NOTE: state uses non-blocking assignments and is reset asynchronously.
  // Later assignments in this block override the defaults set above them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      count_q     <= '0;
      presc_q     <= '0;
      phase_q     <= '0;
      period_q    <= '0;
      symbol_q    <= '0;
      strobe_q    <= 1'b0;
      tx_active_q <= 1'b0;
      underrun_q  <= 1'b0;
      stop_req_q  <= 1'b0;
`ifdef QAM_SEQ_PREAMBLE_EN
      pre_idx_q   <= '0;
`endif
    end else begin
      buf_q    <= buf_d;
      count_q  <= count_d;
      strobe_q <= 1'b0;

      // Sample timebase. It is frozen outside RUN/PREAMBLE. phase_addr wraps
      // naturally because LUT_DEPTH is a power of two.
      if (running) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          phase_q <= phase_q + 1'b1;
          if (phase_q == PHASE_LAST)
            period_q <= (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
        end
      end else begin
        presc_q <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            underrun_q <= 1'b0;
            count_q    <= '0;
            stop_req_q <= 1'b0;
`ifdef QAM_SEQ_PREAMBLE_EN
            state_q     <= S_PREAMBLE;
            symbol_q    <= 2'b11;
            strobe_q    <= 1'b1;
            tx_active_q <= 1'b1;
            pre_idx_q   <= '0;
            phase_q     <= '0;
            period_q    <= '0;
`else
            state_q <= S_FILL;
`endif
          end
        end

        S_FILL: begin
          if (bus.stop) begin
            state_q <= S_IDLE;
            count_q <= '0;
          end else if (count_d == 2'd2) begin
            state_q     <= S_RUN;
            symbol_q    <= buf_d;
            count_q     <= '0;
            phase_q     <= '0;
            period_q    <= '0;
            strobe_q    <= 1'b1;
            tx_active_q <= 1'b1;
          end
        end

        default: begin  // S_RUN, and S_PREAMBLE when enabled
          if (bus.stop) stop_req_q <= 1'b1;
          if (boundary) begin
            if (stop_pend) begin
              // Graceful stop: symbol_out holds its last value.
              state_q     <= S_IDLE;
              tx_active_q <= 1'b0;
`ifdef QAM_SEQ_PREAMBLE_EN
            end else if ((state_q == S_PREAMBLE) && (pre_idx_q != 2'd3)) begin
              // The preamble alternates 11/00. The symbol after an even index is 00.
              symbol_q  <= {2{pre_idx_q[0]}};
              strobe_q  <= 1'b1;
              pre_idx_q <= pre_idx_q + 2'd1;
`endif
            end else if (count_q == 2'd2) begin
              state_q  <= S_RUN;
              symbol_q <= buf_q;
              count_q  <= '0;
              strobe_q <= 1'b1;
            end else begin
              // Starved. Partial bits are kept, including one accepted on this edge.
              state_q     <= S_FILL;
              underrun_q  <= 1'b1;
              tx_active_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.bit_ready     = bit_ready;
  assign bus.en_sample     = tick;
  assign bus.phase_addr    = phase_q;
  assign bus.symbol_out    = symbol_q;
  assign bus.symbol_strobe = strobe_q;
  assign bus.tx_active     = tx_active_q;
  assign bus.underrun      = underrun_q;

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_qam_tx_sequencer
// Directed bench for qam_tx_sequencer. dut0 uses LUT_DEPTH=8,
// PERIODS_PER_SYMBOL=2 and PRESCALE=0, which gives 16-clock symbols. dut3 uses
// the same settings with PRESCALE=2, which gives 48-clock symbols. Expected
// symbols are queued as bits are driven. A monitor pops the queue on each
// symbol_strobe of dut0. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_qam_tx_sequencer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] sb_q [$];

  qam_tx_sequencer_if #(.ADDR_W(3)) if0 ();
  qam_tx_sequencer_if #(.ADDR_W(3)) if3 ();

  qam_tx_sequencer #(.LUT_DEPTH(8), .PERIODS_PER_SYMBOL(2), .PRESCALE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  qam_tx_sequencer #(.LUT_DEPTH(8), .PERIODS_PER_SYMBOL(2), .PRESCALE(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks the post-reset state of every dut0 output.
  task automatic check_zero(input string tag);
    check({tag, "_phase"},  32'(if0.phase_addr),    32'd0);
    check({tag, "_symbol"}, 32'(if0.symbol_out),    32'd0);
    check({tag, "_strobe"}, 32'(if0.symbol_strobe), 32'd0);
    check({tag, "_tx"},     32'(if0.tx_active),     32'd0);
    check({tag, "_under"},  32'(if0.underrun),      32'd0);
    check({tag, "_en"},     32'(if0.en_sample),     32'd0);
    check({tag, "_ready"},  32'(if0.bit_ready),     32'd0);
  endtask

  // Scoreboard: every symbol_strobe of dut0 must match the oldest queued symbol.
  always @(negedge clk) begin
    if (!rst && if0.symbol_strobe) begin
      if (sb_q.size() == 0) check("sb_pending", 32'(sb_q.size()), 32'd1);
      else                  check("sb_symbol", 32'(if0.symbol_out), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if0.start = 1'b0; if0.stop = 1'b0; if0.bit_in = 1'b0; if0.bit_valid = 1'b0;
    if3.start = 1'b0; if3.stop = 1'b0; if3.bit_in = 1'b0; if3.bit_valid = 1'b0;
    nclk(2);
    check_zero("reset");
    rst = 1'b0;
    nclk(1);

`ifdef QAM_SEQ_PREAMBLE_EN
    // Preamble 11,00,11,00. The buffer fills with 1,0 and the data symbol goes out at clock 64.
    sb_q.push_back(2'b11); sb_q.push_back(2'b00);
    sb_q.push_back(2'b11); sb_q.push_back(2'b00);
    sb_q.push_back(2'b10);
    if0.start = 1'b1; if0.bit_valid = 1'b1; if0.bit_in = 1'b1;
    nclk(1);
    if0.start = 1'b0;
    for (int k = 0; k <= 64; k++) begin
      check("pre_strobe", 32'(if0.symbol_strobe), 32'((k % 16) == 0));
      check("pre_under",  32'(if0.underrun),      32'd0);
      check("pre_tx",     32'(if0.tx_active),     32'd1);
      if (k == 1) if0.bit_in = 1'b0;
      if (k < 64) nclk(1);
    end
    check("pre_data", 32'(if0.symbol_out), 32'(2'b10));
    if0.bit_valid = 1'b0;
`else
    // Two symbols 10 and 01. phase_addr sweeps 0..7 twice between the strobes.
    if0.start = 1'b1;
    nclk(1);
    if0.start = 1'b0;
    check("fill_ready", 32'(if0.bit_ready), 32'd1);
    check("fill_tx",    32'(if0.tx_active), 32'd0);
    check("fill_en",    32'(if0.en_sample), 32'd0);
    if0.bit_valid = 1'b1; if0.bit_in = 1'b1;
    nclk(1);
    if0.bit_in = 1'b0;
    sb_q.push_back(2'b10);
    nclk(1);
    for (int k = 0; k <= 16; k++) begin
      check("run_phase",  32'(if0.phase_addr),    32'(k % 8));
      check("run_strobe", 32'(if0.symbol_strobe), 32'((k == 0) || (k == 16)));
      check("run_en",     32'(if0.en_sample),     32'd1);
      check("run_tx",     32'(if0.tx_active),     32'd1);
      if (k == 0) begin if0.bit_valid = 1'b1; if0.bit_in = 1'b0; end
      if (k == 1) begin if0.bit_in = 1'b1; sb_q.push_back(2'b01); end
      if (k == 2) begin check("full_ready", 32'(if0.bit_ready), 32'd0); if0.bit_valid = 1'b0; end
      if (k == 8) check("hold_symbol", 32'(if0.symbol_out), 32'(2'b10));
      if (k < 16) nclk(1);
    end

    // Starvation: the buffer is empty at the next boundary.
    nclk(15);
    check("pre_under", 32'(if0.underrun), 32'd0);
    nclk(1);
    check("under_flag",  32'(if0.underrun),      32'd1);
    check("under_tx",    32'(if0.tx_active),     32'd0);
    check("under_en",    32'(if0.en_sample),     32'd0);
    check("under_ready", 32'(if0.bit_ready),     32'd1);
    check("under_phase", 32'(if0.phase_addr),    32'd0);
    check("under_strb",  32'(if0.symbol_strobe), 32'd0);
    if0.bit_valid = 1'b1; if0.bit_in = 1'b0;
    nclk(1);
    sb_q.push_back(2'b00);
    nclk(1);
    if0.bit_valid = 1'b0;
    check("resume_strb",  32'(if0.symbol_strobe), 32'd1);
    check("resume_tx",    32'(if0.tx_active),     32'd1);
    check("resume_sticky",32'(if0.underrun),      32'd1);

    // A stop at phase 3 of period 0 finishes the symbol. It wins over a full buffer.
    nclk(3);
    check("stop_at_phase", 32'(if0.phase_addr), 32'd3);
    if0.stop = 1'b1; if0.bit_valid = 1'b1; if0.bit_in = 1'b1;
    nclk(1);
    if0.stop = 1'b0;
    nclk(1);
    if0.bit_valid = 1'b0;
    nclk(10);
    check("stop_last_tx",    32'(if0.tx_active),  32'd1);
    check("stop_last_phase", 32'(if0.phase_addr), 32'd7);
    nclk(1);
    check("stop_tx",     32'(if0.tx_active),     32'd0);
    check("stop_en",     32'(if0.en_sample),     32'd0);
    check("stop_ready",  32'(if0.bit_ready),     32'd0);
    check("stop_symbol", 32'(if0.symbol_out),    32'(2'b00));
    check("stop_strobe", 32'(if0.symbol_strobe), 32'd0);
    nclk(5);
    if0.start = 1'b1;
    nclk(1);
    if0.start = 1'b0;
    check("restart_under", 32'(if0.underrun),  32'd0);
    check("restart_ready", 32'(if0.bit_ready), 32'd1);
    check("restart_tx",    32'(if0.tx_active), 32'd0);

    // Asynchronous reset in the middle of a symbol.
    if0.bit_valid = 1'b1; if0.bit_in = 1'b1;
    nclk(1);
    sb_q.push_back(2'b11);
    nclk(1);
    if0.bit_valid = 1'b0;
    nclk(3);
    check("prerst_phase", 32'(if0.phase_addr), 32'd3);
    check("prerst_tx",    32'(if0.tx_active),  32'd1);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    nclk(2);
    rst = 1'b0;
    nclk(3);
    check("postrst_ready", 32'(if0.bit_ready), 32'd0);
    check("postrst_tx",    32'(if0.tx_active), 32'd0);

    // PRESCALE=2: en_sample on every third clock and a 48-clock symbol.
    if3.start = 1'b1;
    nclk(1);
    if3.start = 1'b0;
    if3.bit_valid = 1'b1; if3.bit_in = 1'b1;
    nclk(1);
    if3.bit_in = 1'b0;
    nclk(1);
    for (int j = 0; j <= 48; j++) begin
      check("ps_en",     32'(if3.en_sample),     32'((j % 3) == 2));
      check("ps_phase",  32'(if3.phase_addr),    32'((j / 3) % 8));
      check("ps_strobe", 32'(if3.symbol_strobe), 32'((j == 0) || (j == 48)));
      if (j == 0) begin
        check("ps_sym0", 32'(if3.symbol_out), 32'(2'b10));
        if3.bit_in = 1'b0;
      end
      if (j == 1) if3.bit_in = 1'b1;
      if (j == 2) if3.bit_valid = 1'b0;
      if (j == 48) check("ps_sym1", 32'(if3.symbol_out), 32'(2'b01));
      if (j < 48) nclk(1);
    end
`endif

    nclk(1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
